// File: rtl/seq_pkg.sv
// Shared definitions for the serial run-detect pair: generator FSM encoding,
// detector FSM encoding and default sizing.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } gen_state_t;

    typedef enum logic [1:0] {
        DET_IDLE = 2'd0,
        DET_S0   = 2'd1,
        DET_S1   = 2'd2
    } det_state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_LEN_W  = 5;
    localparam int DEF_RPT_W  = 4;
    localparam int DEF_GAP    = 1;

    // The gap counter only ever holds GAP-1, so it needs clog2(GAP) bits (min 1).
    function automatic int gap_cnt_w(input int gap);
        return (gap > 1) ? $clog2(gap) : 1;
    endfunction

endpackage

// File: rtl/seq_exp.sv
// Two-deep history of the serial stream and the registered "two ones in a row"
// flag a downstream detector is expected to show.
module seq_exp (
    input  logic clk,
    input  logic rst_n,
    input  logic w_next,
    output logic exp_z
);

    logic h1;
    logic h2;

    // Fed with the value w_o takes at each edge, so h1/h2 hold w_o of the
    // two cycles preceding the one in which exp_z is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1    <= 1'b0;
            h2    <= 1'b0;
            exp_z <= 1'b0;
        end else begin
            h1    <= w_next;
            h2    <= h1;
            exp_z <= h1 & h2;
        end
    end

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: accepts a pattern command, shifts it out MSB-first
// with optional zero-filled repeats, and produces the expected detector output.
module seq_gen
    import seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int RPT_W  = DEF_RPT_W,
    parameter int GAP    = DEF_GAP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] pat_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [RPT_W-1:0]  rpt_i,
    output logic              w_o,
    output logic              w_vld_o,
    output logic              exp_z_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int               GAP_W   = gap_cnt_w(GAP);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

    gen_state_t        state;
    gen_state_t        state_n;
    logic [DATA_W-1:0] pat_q;
    logic [DATA_W-1:0] pat_n;
    logic [DATA_W-1:0] bit_mask;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_n;
    logic [LEN_W-1:0]  len_clamp;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  idx_n;
    logic [RPT_W-1:0]  rpt_q;
    logic [RPT_W-1:0]  rpt_n;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_n;
    logic              w_d;

    assign len_clamp = (len_i > MAX_LEN) ? MAX_LEN : len_i;
    assign ready_o   = (state == ST_IDLE);
    assign busy_o    = (state != ST_IDLE);

    always_comb begin
        state_n = state;
        pat_n   = pat_q;
        len_n   = len_q;
        idx_n   = idx;
        rpt_n   = rpt_q;
        gap_n   = gap_q;
        case (state)
            ST_IDLE: begin
                if (valid_i) begin
                    pat_n = pat_i;
                    len_n = len_clamp;
                    rpt_n = rpt_i;
                    idx_n = len_clamp - 1'b1;
                    state_n = (len_clamp == '0) ? ST_DONE : ST_SEND;
                end
            end
            ST_SEND: begin
                if (idx != '0) begin
                    idx_n = idx - 1'b1;
                end else if (rpt_q != '0) begin
                    rpt_n = rpt_q - 1'b1;
                    if (GAP == 0) begin
                        idx_n = len_q - 1'b1;
                    end else begin
                        state_n = ST_GAP;
                        gap_n   = GAP_W'(GAP - 1);
                    end
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_n = ST_SEND;
                    idx_n   = len_q - 1'b1;
                end else begin
                    gap_n = gap_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state view so the first bit
    // appears in the cycle right after the accept edge.
    assign bit_mask = DATA_W'(1) << idx_n;
    assign w_d      = (state_n == ST_SEND) && ((pat_n & bit_mask) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx     <= '0;
            rpt_q   <= '0;
            gap_q   <= '0;
            w_o     <= 1'b0;
            w_vld_o <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state   <= state_n;
            pat_q   <= pat_n;
            len_q   <= len_n;
            idx     <= idx_n;
            rpt_q   <= rpt_n;
            gap_q   <= gap_n;
            w_o     <= w_d;
            w_vld_o <= (state_n == ST_SEND);
            done_o  <= (state_n == ST_DONE);
        end
    end

    seq_exp u_exp (
        .clk    (clk),
        .rst_n  (rst_n),
        .w_next (w_d),
        .exp_z  (exp_z_o)
    );

endmodule
